// File: rtl/alu_seq_pkg.sv
// Shared opcode, ALU pin-encoding and FSM state constants for the ALU op sequencer.
package alu_seq_pkg;

   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_SUB = 3'd1;
   localparam logic [2:0] OP_AND = 3'd2;
   localparam logic [2:0] OP_OR  = 3'd3;
   localparam logic [2:0] OP_XOR = 3'd4;

   // ALU control pins packed as {SEL1, SEL0, B_inv}
   localparam logic [2:0] PINS_ADD = 3'b000;
   localparam logic [2:0] PINS_SUB = 3'b001;
   localparam logic [2:0] PINS_AND = 3'b010;
   localparam logic [2:0] PINS_OR  = 3'b100;
   localparam logic [2:0] PINS_XOR = 3'b110;

   localparam logic [0:0] ST_IDLE   = 1'b0;
   localparam logic [0:0] ST_SETTLE = 1'b1;

   function automatic logic op_legal(input logic [2:0] op);
      return (op <= OP_XOR);
   endfunction

   function automatic logic [2:0] op_pins(input logic [2:0] op);
      logic [2:0] p;
      case (op)
         OP_ADD:  p = PINS_ADD;
         OP_SUB:  p = PINS_SUB;
         OP_AND:  p = PINS_AND;
         OP_OR:   p = PINS_OR;
         OP_XOR:  p = PINS_XOR;
         default: p = PINS_ADD;
      endcase
      return p;
   endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Command and response valid/ready bundle between a requester and the ALU op sequencer.
interface alu_op_sequencer_if #(
   parameter int TAG_W = 4
) ();

   logic             cmd_valid;
   logic             cmd_ready;
   logic [2:0]       cmd_op;
   logic [3:0]       cmd_a;
   logic [3:0]       cmd_b;
   logic [TAG_W-1:0] cmd_tag;

   logic             rsp_valid;
   logic             rsp_ready;
   logic [3:0]       rsp_out;
   logic             rsp_ov;
   logic             rsp_err;
   logic [TAG_W-1:0] rsp_tag;

   modport master (
      output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_tag, rsp_ready,
      input  cmd_ready, rsp_valid, rsp_out, rsp_ov, rsp_err, rsp_tag
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_tag, rsp_ready,
      output cmd_ready, rsp_valid, rsp_out, rsp_ov, rsp_err, rsp_tag
   );

endinterface

// File: rtl/alu_rsp_fifo.sv
// Small synchronous response FIFO. Head data reads as zero while empty so the
// response bus is quiet whenever nothing is valid.
module alu_rsp_fifo #(
   parameter int WIDTH = 10,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push;
   logic             do_pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign full     = (count_q == CNT_W'(DEPTH));
   assign empty    = (count_q == '0);
   assign do_pop   = pop && !empty;
   // a pop frees a slot in the same edge, so push-while-full is legal alongside a pop
   assign do_push  = push && (!full || do_pop);
   assign pop_data = empty ? '0 : mem_q[rd_ptr_q];

   // next-state for storage, pointers and occupancy
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = push_data;
         wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (do_pop) begin
         rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // FIFO state registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/alu_op_sequencer.sv
// Command front end for the 4-bit combinational ALU: drives registered operand and
// select pins, holds them for a settle window, samples OUT/Ov and queues a tagged result.
//
//  state     | meaning
//  ----------+-------------------------------------------------------------
//  ST_IDLE   | ready for a command when the response FIFO has room
//  ST_SETTLE | ALU pins held; counter runs down to the sample edge
module alu_op_sequencer
   import alu_seq_pkg::*;
#(
   parameter int SETTLE_CYCLES = 2,
   parameter int RSP_DEPTH     = 2,
   parameter int TAG_W         = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   alu_op_sequencer_if.slave   bus,
   output logic                busy,
   output logic                A0,
   output logic                A1,
   output logic                A2,
   output logic                A3,
   output logic                B0,
   output logic                B1,
   output logic                B2,
   output logic                B3,
   output logic                B_inv,
   output logic                SEL0,
   output logic                SEL1,
   input  logic                OUT0,
   input  logic                OUT1,
   input  logic                OUT2,
   input  logic                OUT3,
   input  logic                Ov
);

   localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam int RSP_W = 4 + 1 + 1 + TAG_W;

   logic [0:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [3:0]       a_q, a_d;
   logic [3:0]       b_q, b_d;
   logic [2:0]       ctl_q, ctl_d;
   logic [TAG_W-1:0] tag_q, tag_d;

   logic             accept;
   logic             push;
   logic [RSP_W-1:0] push_data;
   logic [RSP_W-1:0] head;
   logic             fifo_full;
   logic             fifo_empty;

   // only one command is ever in flight, so a free slot at accept is a slot at push
   assign bus.cmd_ready = (state_q == ST_IDLE) && !fifo_full;
   assign accept        = bus.cmd_valid && bus.cmd_ready;
   assign busy          = (state_q != ST_IDLE);

   assign {A3, A2, A1, A0}    = a_q;
   assign {B3, B2, B1, B0}    = b_q;
   assign {SEL1, SEL0, B_inv} = ctl_q;

   // FSM, pin loading and response construction
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      a_d       = a_q;
      b_d       = b_q;
      ctl_d     = ctl_q;
      tag_d     = tag_q;
      push      = 1'b0;
      push_data = '0;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               if (op_legal(bus.cmd_op)) begin
                  state_d = ST_SETTLE;
                  cnt_d   = CNT_W'(SETTLE_CYCLES - 1);
                  a_d     = bus.cmd_a;
                  b_d     = bus.cmd_b;
                  ctl_d   = op_pins(bus.cmd_op);
                  tag_d   = bus.cmd_tag;
               end else begin
                  // illegal opcode answers at once and leaves the ALU pins alone
                  push      = 1'b1;
                  push_data = {4'b0000, 1'b0, 1'b1, bus.cmd_tag};
               end
            end
         end
         ST_SETTLE: begin
            if (cnt_q == '0) begin
               push      = 1'b1;
               push_data = {OUT3, OUT2, OUT1, OUT0, Ov, 1'b0, tag_q};
               state_d   = ST_IDLE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // sequencer state and registered ALU pins
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         ctl_q   <= '0;
         tag_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         ctl_q   <= ctl_d;
         tag_q   <= tag_d;
      end
   end

   alu_rsp_fifo #(
      .WIDTH (RSP_W),
      .DEPTH (RSP_DEPTH)
   ) u_rsp_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .push_data (push_data),
      .pop       (bus.rsp_ready),
      .pop_data  (head),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   assign bus.rsp_valid = !fifo_empty;
   assign {bus.rsp_out, bus.rsp_ov, bus.rsp_err, bus.rsp_tag} = head;

endmodule
